dot_seq_18: RTL
===============

Name: dot_seq_18

Overview:
- Sequencer for one dot-product channel of layer 18.
- Each pass, the channel's load input must rise with a given weight chip-select (cs) applied, stay high until the channel raises valid, and then drop so the next rising edge re-initialises the channel.
- This block steps cs through 0..NUM_CS-1 and captures each channel result. It presents each result on a valid/ready output port tagged with its index, and signals completion.

Parameters:
- NUM_CS, 12, number of weight banks/passes per feature vector (1..16).
- DLEN, `data_len, result width (from num_data.v).
- TIMEOUT, 64, max cycles in RUN before watchdog fires (only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- d_valid  in  1  feature vector on the channel's d bus is stable; sampled with start.
- ch_valid  in  1  channel result valid.
- ch_q  in  DLEN  channel result.
- load  out  1  channel load.
- cs  out  4  weight bank select.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DLEN  captured result.
- out_idx  out  4  cs that produced out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  sticky watchdog flag (0 when feature absent).

Behaviour:
- Reset (async, any state): state=IDLE; load=0, cs=0, out_valid=0, out_data=0, out_idx=0, done=0, err=0. Reset mid-sequence abandons the sequence; no partial-result output follows.
- All outputs are registered.
- FSM states: IDLE, ARM, RUN, HOLD, GAP, DONE.
- IDLE:
  - start && d_valid -> ARM, with cs<=0.
  - start without d_valid is ignored (stay IDLE).
- ARM: load<=1 -> RUN. cs is stable since at least the previous cycle, so load rises with cs already valid.
- RUN:
  - load held at 1.
  - ch_valid==1 -> capture out_data<=ch_q, out_idx<=cs, out_valid<=1, load<=0 -> HOLD.
  - ch_valid is ignored in every state except RUN.
- HOLD:
  - out_valid held until sampled out_ready==1.
  - On the accept cycle, out_valid<=0. If cs==NUM_CS-1 -> DONE, else cs<=cs+1 -> GAP.
  - out_ready high on the first HOLD cycle gives a one-cycle HOLD.
  - out_data and out_idx stay stable while out_valid=1.
- GAP: one cycle, load=0 -> ARM. This guarantees load stays low for at least 2 cycles between passes, so the channel sees a clean rising edge and its valid has cleared.
- DONE: done=1 for one cycle -> IDLE. cs stays at NUM_CS-1 until the next start.
- start asserted while busy is ignored; no queuing.
- Pass latency: ARM (1) + channel latency + HOLD (≥1) + GAP (1).
- Back-to-back throughput with out_ready tied high: one result per channel latency + 3 cycles.
- cs never exceeds NUM_CS-1. No wrap occurs within a sequence.

Optional Feature:
- Macro: DOT_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A counter runs in RUN, clearing on entry to RUN.
  - If it reaches TIMEOUT without ch_valid: err<=1 (sticky until rst), load<=0, state -> DONE (done pulses), no out_valid for that pass.
- Without the macro: no counter, err tied to 0, RUN waits indefinitely.

Decomposition:
- Shared package/header (alongside num_data.v) holds:
  - state encoding constants (IDLE..DONE, 3-bit);
  - the NUM_CS default;
  - the cs width (4).
- No sub-module required. If desired, the out_data/out_idx/out_valid holding register can be a generic sub-module dot_out_reg, reusable for other layers' sequencers.

Test Plan:
- Basic sequence:
  - Stimulus: channel model with a 14-cycle fixed latency; out_ready=1; start+d_valid pulsed.
  - Required response: 12 results with out_idx 0..11 in order; out_data equal to the model values; one done pulse after idx 11; busy deasserts the cycle after done.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles at idx 3.
  - Required response: out_valid, out_data and out_idx stable for all 5 cycles; load stays 0; idx 4 starts only after the accept.
- Re-edge check:
  - Required response: between consecutive passes, load is low for ≥2 cycles, and cs changes only while load=0.
- Ignored start:
  - Stimulus: start while busy, and start without d_valid in IDLE.
  - Required response: no effect; sequence count unchanged.
- Mid-operation reset:
  - Stimulus: rst asserted during RUN of idx 5, then released.
  - Required response: immediate load=0, cs=0, out_valid=0, busy=0; a fresh start reproduces idx 0..11.
- Watchdog (DOT_SEQ_WATCHDOG_EN, TIMEOUT=64):
  - Stimulus: channel never asserts valid at idx 2.
  - Required response: after 64 RUN cycles, err=1 and done pulses; no out_valid for idx 2. With the macro undefined, the same stimulus leaves the block in RUN with load=1 and err=0.

Source files
------------

// File: rtl/dot_seq_18_pkg.sv
// dot_seq_18_pkg
// Shared constants and types for the layer-18 dot-product channel sequencer.
//   state_t      : 3-bit FSM encoding IDLE..DONE
//   NUM_CS_DEF   : default number of weight banks / passes
//   CS_W         : width of the weight bank select
//   DLEN_DEF     : result width (matches the data_len value of num_data.v)
//   TIMEOUT_DEF  : default watchdog limit (used with DOT_SEQ_WATCHDOG_EN)
package dot_seq_18_pkg;

  localparam int NUM_CS_DEF  = 12;
  localparam int CS_W        = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int DLEN_DEF    = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/dot_out_reg.sv
// dot_out_reg
// Generic result holding register for a sequencer's valid/ready output.
// A capture loads data+idx and raises valid; data and idx then stay frozen
// until accept drops valid. Capture wins over accept (they never coincide
// in the sequencer, which only captures in RUN and accepts in HOLD).
//   clk, rst       : clock, async active-high reset
//   capture        : load cap_data/cap_idx, set valid
//   cap_data/idx   : values to capture
//   accept         : downstream took the result, clear valid
//   valid/data/idx : registered outputs
module dot_out_reg #(
  parameter int DW = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [DW-1:0] cap_data,
  input  logic [IW-1:0] cap_idx,
  input  logic          accept,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [IW-1:0] idx
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      idx   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= cap_data;
      idx   <= cap_idx;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dot_seq_18.sv
// dot_seq_18
// Sequencer for one dot-product channel of layer 18. Steps the weight bank
// select cs through 0..NUM_CS-1, pulsing the channel's load for each pass
// (load only ever rises with cs already settled, and stays low >= 2 cycles
// between passes), captures each channel result and offers it on a
// valid/ready port tagged with the cs that produced it.
// Optional watchdog: define DOT_SEQ_WATCHDOG_EN to abort a pass that waits
// TIMEOUT cycles in RUN without ch_valid (err sticky, done pulses).
//   clk, rst           : clock, async active-high reset
//   start, d_valid     : begin a sequence (both sampled in IDLE only)
//   ch_valid, ch_q     : channel result
//   load, cs           : channel load and weight bank select
//   out_valid/ready    : result handshake; out_data/out_idx payload
//   busy               : not IDLE; done: one-cycle end pulse; err: watchdog
module dot_seq_18
  import dot_seq_18_pkg::*;
#(
  parameter int NUM_CS  = NUM_CS_DEF,
  parameter int DLEN    = DLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            d_valid,
  input  logic            ch_valid,
  input  logic [DLEN-1:0] ch_q,
  output logic            load,
  output logic [CS_W-1:0] cs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DLEN-1:0] out_data,
  output logic [CS_W-1:0] out_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [CS_W-1:0] CS_LAST = CS_W'(NUM_CS - 1);

  state_t state;
  logic   cap, acc, wd_fire;

  assign cap = (state == S_RUN)  && ch_valid;
  assign acc = (state == S_HOLD) && out_ready;

`ifdef DOT_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_r;

  // wd_cnt is held at 0 outside RUN, so it counts RUN cycles of the
  // current pass; it fires on the TIMEOUT-th cycle without ch_valid.
  assign wd_fire = (state == S_RUN) && !ch_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err     = err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      wd_cnt <= (state == S_RUN) ? wd_cnt + 1'b1 : '0;
      if (wd_fire) err_r <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      load  <= 1'b0;
      cs    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start && d_valid) begin
          cs    <= '0;
          busy  <= 1'b1;
          state <= S_ARM;
        end
        // cs was set at least one cycle earlier, so load rises on a stable cs
        S_ARM: begin
          load  <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: if (ch_valid) begin
          load  <= 1'b0;
          state <= S_HOLD;
        end else if (wd_fire) begin
          load  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_HOLD: if (out_ready) begin
          if (cs == CS_LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cs    <= cs + 1'b1;
            state <= S_GAP;
          end
        end
        // extra low cycle so the channel sees a clean load edge
        S_GAP:  state <= S_ARM;
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          load  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  dot_out_reg #(.DW(DLEN), .IW(CS_W)) u_out (
    .clk     (clk),
    .rst     (rst),
    .capture (cap),
    .cap_data(ch_q),
    .cap_idx (cs),
    .accept  (acc),
    .valid   (out_valid),
    .data    (out_data),
    .idx     (out_idx)
  );

endmodule
